// File: rtl/helper_axis_generator.sv
// AXIS stream source: emits a counter or Galois-LFSR sequence with a rotating
// valid-throttle pattern, an optional final-beat marker and AXIS hold semantics.
module helper_axis_generator #(
  parameter int                         DATA_WIDTH    = 10,
  parameter int                         COUNT         = 16,
  parameter int                         MODE          = 0,
  parameter logic [DATA_WIDTH-1:0]      START_VALUE   = '0,
  parameter logic [DATA_WIDTH-1:0]      STEP          = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0]      POLY          = DATA_WIDTH'('h240),
  parameter int                         PATTERN_WIDTH = 16,
  parameter logic [PATTERN_WIDTH-1:0]   VALID_PATTERN = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  output_valid,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_last,
  input  logic                  output_ready,
  output logic                  done,
  output logic [31:0]           sent_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // An all-zero LFSR would lock up, so the seed is forced to 1 in that case.
  localparam logic [DATA_WIDTH-1:0] SEED =
    (MODE == 1 && START_VALUE == '0) ? DATA_WIDTH'(1) : START_VALUE;

  state_t                     state, state_next;
  logic [PATTERN_WIDTH-1:0]   pattern, pattern_next;
  logic [DATA_WIDTH-1:0]      seq, seq_next;
  logic [DATA_WIDTH-1:0]      seq_step;
  logic [31:0]                loaded, loaded_next;
  logic                       valid_next, last_next, done_next;
  logic [DATA_WIDTH-1:0]      data_next;
  logic [31:0]                sent_next;
  logic                       handshake, slot, beats_left;

  always_comb begin
    if (MODE == 1) seq_step = seq[0] ? ((seq >> 1) ^ POLY) : (seq >> 1);
    else           seq_step = seq + STEP;
  end

  assign handshake  = output_valid && output_ready;
  assign beats_left = (COUNT == 0) || (loaded < 32'(COUNT));
  assign slot       = enable && ((state == IDLE) ||
                                 (state == RUN && (!output_valid || handshake)));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next   = state;
    pattern_next = pattern;
    seq_next     = seq;
    loaded_next  = loaded;
    valid_next   = output_valid;
    data_next    = output_data;
    last_next    = output_last;
    done_next    = done;
    sent_next    = handshake ? sent_count + 32'd1 : sent_count;

    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (handshake && output_last) state_next = DONE;
      default: state_next = state;
    endcase

    if (state == RUN && handshake && output_last) begin
      valid_next = 1'b0;
      last_next  = 1'b0;
      done_next  = 1'b1;
    end else if (slot) begin
      pattern_next = (pattern >> 1) | (pattern << (PATTERN_WIDTH - 1));
      if (pattern[0] && beats_left) begin
        valid_next  = 1'b1;
        data_next   = seq;
        last_next   = (COUNT != 0) && (loaded == 32'(COUNT - 1));
        seq_next    = seq_step;
        loaded_next = loaded + 32'd1;
      end else begin
        valid_next = 1'b0;
        last_next  = 1'b0;
      end
    end else if (state == RUN && (!output_valid || handshake)) begin
      // enable low with nothing pending: go idle on the bus, pattern frozen
      valid_next = 1'b0;
      last_next  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pattern      <= VALID_PATTERN;
      seq          <= SEED;
      loaded       <= '0;
      output_valid <= 1'b0;
      output_data  <= '0;
      output_last  <= 1'b0;
      done         <= 1'b0;
      sent_count   <= '0;
    end else begin
      state        <= state_next;
      pattern      <= pattern_next;
      seq          <= seq_next;
      loaded       <= loaded_next;
      output_valid <= valid_next;
      output_data  <= data_next;
      output_last  <= last_next;
      done         <= done_next;
      sent_count   <= sent_next;
    end
  end

endmodule

// File: tb/tb_helper_axis_generator.sv
// Bench for helper_axis_generator: four configurations checked against
// sequences computed from the arithmetic/LFSR definitions, under random ready.
module tb_helper_axis_generator;

  logic clk = 1'b0;
  logic rst;
  logic en  [4];
  logic rdy [4];
  logic v   [4];
  logic l   [4];
  logic dn  [4];
  logic [7:0]  d  [4];
  logic [31:0] sc [4];
  logic [7:0] d0, d1, d3;
  logic [3:0] d2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign d[0] = d0;
  assign d[1] = d1;
  assign d[2] = {4'b0, d2};
  assign d[3] = d3;

  helper_axis_generator #(.DATA_WIDTH(8), .COUNT(4), .MODE(0), .START_VALUE(8'h10),
    .STEP(8'd3), .POLY(8'hB8)) u0 (
    .clk(clk), .rst(rst), .enable(en[0]), .output_valid(v[0]), .output_data(d0),
    .output_last(l[0]), .output_ready(rdy[0]), .done(dn[0]), .sent_count(sc[0]));

  helper_axis_generator #(.DATA_WIDTH(8), .COUNT(4), .MODE(0), .START_VALUE(8'h10),
    .STEP(8'd3), .POLY(8'hB8), .PATTERN_WIDTH(4), .VALID_PATTERN(4'b0101)) u1 (
    .clk(clk), .rst(rst), .enable(en[1]), .output_valid(v[1]), .output_data(d1),
    .output_last(l[1]), .output_ready(rdy[1]), .done(dn[1]), .sent_count(sc[1]));

  helper_axis_generator #(.DATA_WIDTH(4), .COUNT(5), .MODE(1), .START_VALUE(4'h0),
    .STEP(4'h1), .POLY(4'hC)) u2 (
    .clk(clk), .rst(rst), .enable(en[2]), .output_valid(v[2]), .output_data(d2),
    .output_last(l[2]), .output_ready(rdy[2]), .done(dn[2]), .sent_count(sc[2]));

  helper_axis_generator #(.DATA_WIDTH(8), .COUNT(4), .MODE(0), .START_VALUE(8'hFE),
    .STEP(8'd1), .POLY(8'hB8)) u3 (
    .clk(clk), .rst(rst), .enable(en[3]), .output_valid(v[3]), .output_data(d3),
    .output_last(l[3]), .output_ready(rdy[3]), .done(dn[3]), .sent_count(sc[3]));

  // Expected beat k of each configuration, from the sequence definitions.
  function automatic logic [7:0] exp_val(input int id, input int k);
    logic [3:0] x;
    case (id)
      0, 1: return 8'(32'h10 + k * 3);
      2: begin
        x = 4'h1;
        for (int i = 0; i < k; i++) x = x[0] ? ((x >> 1) ^ 4'hC) : (x >> 1);
        return {4'b0, x};
      end
      default: return 8'(32'hFE + k);
    endcase
  endfunction

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin en[i] = 1'b0; rdy[i] = 1'b0; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives one instance with random enable/ready until n beats are accepted,
  // checking beat order, last marker, hold rule and final state.
  task automatic run_stream(input int id, input int n, input int pct);
    logic pv, pr, pl;
    logic [7:0] pd;
    int k = 0;
    en[id] = 1'b1;
    rdy[id] = ($urandom_range(99) < pct);
    pv = v[id]; pr = rdy[id]; pd = d[id]; pl = l[id];
    for (int cyc = 0; cyc < 400 && k < n; cyc++) begin
      @(posedge clk); #1;
      if (pv && pr) begin
        total_cnt++;
        if (pd !== exp_val(id, k) || pl !== (k == n - 1) || sc[id] !== 32'(k + 1))
          $display("FAIL beat id=%0d k=%0d: data=%h last=%b sent=%0d, expected data=%h last=%b sent=%0d",
                   id, k, pd, pl, sc[id], exp_val(id, k), (k == n - 1), k + 1);
        else pass_cnt++;
        k++;
      end else if (pv) begin
        total_cnt++;
        if (v[id] !== 1'b1 || d[id] !== pd || l[id] !== pl)
          $display("FAIL hold id=%0d: valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                   id, v[id], d[id], l[id], pd, pl);
        else pass_cnt++;
      end
      en[id] = ($urandom_range(3) != 0);
      rdy[id] = ($urandom_range(99) < pct);
      pv = v[id]; pr = rdy[id]; pd = d[id]; pl = l[id];
    end
    total_cnt++;
    if (k != n) $display("FAIL timeout id=%0d: beats=%0d, expected %0d", id, k, n);
    else pass_cnt++;
    total_cnt++;
    if (v[id] !== 1'b0 || l[id] !== 1'b0 || dn[id] !== 1'b1 || sc[id] !== 32'(n))
      $display("FAIL end id=%0d: valid=%b last=%b done=%b sent=%0d, expected 0 0 1 %0d",
               id, v[id], l[id], dn[id], sc[id], n);
    else pass_cnt++;
    en[id] = 1'b1; rdy[id] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total_cnt++;
      if (v[id] !== 1'b0 || dn[id] !== 1'b1 || sc[id] !== 32'(n))
        $display("FAIL after_done id=%0d: valid=%b done=%b sent=%0d, expected 0 1 %0d",
                 id, v[id], dn[id], sc[id], n);
      else pass_cnt++;
    end
    en[id] = 1'b0; rdy[id] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (v[i] !== 1'b0 || d[i] !== 8'h00 || l[i] !== 1'b0 || dn[i] !== 1'b0 || sc[i] !== 32'd0)
        $display("FAIL reset id=%0d: valid=%b data=%h last=%b done=%b sent=%0d, expected all 0",
                 i, v[i], d[i], l[i], dn[i], sc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    do_reset();
    en[0] = 1'b1; rdy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (v[0] !== 1'b1 || d[0] !== exp_val(0, i) || l[0] !== (i == 3))
        $display("FAIL basic beat %0d: valid=%b data=%h last=%b, expected 1 %h %b",
                 i, v[0], d[0], l[0], exp_val(0, i), (i == 3));
      else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++;
    if (v[0] !== 1'b0 || dn[0] !== 1'b1 || sc[0] !== 32'd4 || l[0] !== 1'b0)
      $display("FAIL basic end: valid=%b done=%b sent=%0d last=%b, expected 0 1 4 0",
               v[0], dn[0], sc[0], l[0]);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    en[0] = 1'b1; rdy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rdy[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total_cnt++;
      if (v[0] !== 1'b1 || d[0] !== 8'h13 || sc[0] !== 32'd1)
        $display("FAIL stall: valid=%b data=%h sent=%0d, expected 1 13 1", v[0], d[0], sc[0]);
      else pass_cnt++;
    end
    rdy[0] = 1'b1;
    for (int i = 2; i < 4; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (v[0] !== 1'b1 || d[0] !== exp_val(0, i))
        $display("FAIL stall resume %0d: valid=%b data=%h, expected 1 %h", i, v[0], d[0], exp_val(0, i));
      else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++;
    if (dn[0] !== 1'b1 || sc[0] !== 32'd4 || v[0] !== 1'b0)
      $display("FAIL stall end: done=%b sent=%0d valid=%b, expected 1 4 0", dn[0], sc[0], v[0]);
    else pass_cnt++;
  endtask

  task automatic test_pattern();
    logic [3:0] pat = 4'b0101;
    int beat = 0;
    do_reset();
    en[1] = 1'b1; rdy[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (v[1] !== pat[i % 4] || (pat[i % 4] && d[1] !== exp_val(1, beat)))
        $display("FAIL pattern cycle %0d: valid=%b data=%h, expected valid=%b data=%h",
                 i, v[1], d[1], pat[i % 4], exp_val(1, beat));
      else pass_cnt++;
      if (pat[i % 4]) beat++;
    end
    @(posedge clk); #1;
    total_cnt++;
    if (dn[1] !== 1'b1 || sc[1] !== 32'd4 || v[1] !== 1'b0)
      $display("FAIL pattern end: done=%b sent=%0d valid=%b, expected 1 4 0", dn[1], sc[1], v[1]);
    else pass_cnt++;
  endtask

  task automatic test_midreset();
    do_reset();
    en[0] = 1'b1; rdy[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rdy[0] = 1'b0;
    total_cnt++;
    if (sc[0] !== 32'd2)
      $display("FAIL midreset pre: sent=%0d, expected 2", sc[0]);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if (v[0] !== 1'b0 || sc[0] !== 32'd0 || dn[0] !== 1'b0 || l[0] !== 1'b0)
      $display("FAIL midreset: valid=%b sent=%0d done=%b last=%b, expected all 0",
               v[0], sc[0], dn[0], l[0]);
    else pass_cnt++;
    run_stream(0, 4, 100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_pattern();
    for (int r = 0; r < 3; r++) begin
      do_reset(); run_stream(0, 4, 50);
      do_reset(); run_stream(2, 5, 60);
      do_reset(); run_stream(3, 4, 40);
    end
    test_midreset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
